// File: rtl/xup_shift_seq_nbit_pkg.sv
// Shared encodings for the sequential n-bit shift engine.
// Imported by the engine top and its combinational shift stage.
package xup_shift_seq_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_LEFT      = 1'b0;
  localparam logic DIR_RIGHT     = 1'b1;
  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ROTATE  = 1'b1;

endpackage

// File: rtl/xup_shift_nbit.sv
// Combinational n-bit shift stage: logical or rotate, left or right.
// Only the zero-delay (purely combinational) form is built.
module xup_shift_nbit
  import xup_shift_seq_nbit_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int NBITS = 1,
  parameter int DELAY = 0
) (
  input  logic [SIZE-1:0] parallel_in,
  input  logic            dir,
  input  logic            shift_type,
  output logic [SIZE-1:0] parallel_out
);

  logic [SIZE-1:0] w_lsh;
  logic [SIZE-1:0] w_rsh;
  logic [SIZE-1:0] w_lrot;
  logic [SIZE-1:0] w_rrot;
  logic [SIZE-1:0] w_res;

  assign w_lsh  = parallel_in << NBITS;
  assign w_rsh  = parallel_in >> NBITS;
  assign w_lrot = w_lsh | (parallel_in >> (SIZE - NBITS));
  assign w_rrot = w_rsh | (parallel_in << (SIZE - NBITS));

  always_comb begin
    w_res = w_lsh;
    unique case (1'b1)
      (dir == DIR_LEFT)  && (shift_type == SHIFT_LOGICAL): w_res = w_lsh;
      (dir == DIR_RIGHT) && (shift_type == SHIFT_LOGICAL): w_res = w_rsh;
      (dir == DIR_LEFT)  && (shift_type == SHIFT_ROTATE):  w_res = w_lrot;
      (dir == DIR_RIGHT) && (shift_type == SHIFT_ROTATE):  w_res = w_rrot;
      default: w_res = w_lsh;
    endcase
  end

  generate
    if (DELAY == 0) begin : g_comb
      assign parallel_out = w_res;
    end
  endgenerate

endmodule

// File: rtl/xup_shift_seq_nbit.sv
// Sequential shift engine: register + paced steps through xup_shift_nbit.
// Reports done after the programmed number of steps; abort returns to idle.
module xup_shift_seq_nbit
  import xup_shift_seq_nbit_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int NBITS    = 1,
  parameter int CNT_W    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SIZE-1:0]  load_data,
  input  logic             start,
  input  logic [CNT_W-1:0] step_count,
  input  logic             dir,
  input  logic             shift_type,
  input  logic             abort,
  output logic [SIZE-1:0]  q,
  output logic             busy,
  output logic             done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t           r_state, w_state_n;
  logic [SIZE-1:0]  r_q, w_q_n;
  logic             r_dir, w_dir_n;
  logic             r_type, w_type_n;
  logic [CNT_W-1:0] r_rem, w_rem_n;
  logic [TW-1:0]    r_tick, w_tick_n;
  logic [SIZE-1:0]  w_shifted;

  xup_shift_nbit #(
    .SIZE  (SIZE),
    .NBITS (NBITS),
    .DELAY (0)
  ) u_stage (
    .parallel_in  (r_q),
    .dir          (r_dir),
    .shift_type   (r_type),
    .parallel_out (w_shifted)
  );

  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_dir_n   = r_dir;
    w_type_n  = r_type;
    w_rem_n   = r_rem;
    w_tick_n  = r_tick;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          w_q_n     = load_data;
          w_state_n = ST_IDLE;
        end else if (start) begin
          w_dir_n   = dir;
          w_type_n  = shift_type;
          w_rem_n   = step_count;
          w_tick_n  = '0;
          w_state_n = (step_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a shift that falls due on the same edge.
        if (abort) begin
          w_state_n = ST_IDLE;
          w_rem_n   = '0;
          w_tick_n  = '0;
        end else if (r_tick == TICK_LAST) begin
          w_q_n    = w_shifted;
          w_tick_n = '0;
          w_rem_n  = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) w_state_n = ST_DONE;
        end else begin
          w_tick_n = r_tick + TW'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_dir   <= DIR_LEFT;
      r_type  <= SHIFT_LOGICAL;
      r_rem   <= '0;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_dir   <= w_dir_n;
      r_type  <= w_type_n;
      r_rem   <= w_rem_n;
      r_tick  <= w_tick_n;
    end
  end

  assign q    = r_q;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_xup_shift_seq_nbit.sv
// Directed bench for xup_shift_seq_nbit at TICK_DIV=1 (dut a) and 4 (dut b).
// Expected values are hand-derived shift results and cycle timings.
module tb_xup_shift_seq_nbit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_data = '0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [3:0] step_count = '0;
  logic       dir = 1'b0;
  logic       shift_type = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] q_a, q_b;
  logic       busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xup_shift_seq_nbit #(
    .SIZE(8), .NBITS(1), .CNT_W(4), .TICK_DIV(1)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .load(load),
    .load_data(load_data), .start(start_a),
    .step_count(step_count), .dir(dir),
    .shift_type(shift_type), .abort(abort),
    .q(q_a), .busy(busy_a), .done(done_a)
  );

  xup_shift_seq_nbit #(
    .SIZE(8), .NBITS(1), .CNT_W(4), .TICK_DIV(4)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .load(load),
    .load_data(load_data), .start(start_b),
    .step_count(step_count), .dir(dir),
    .shift_type(shift_type), .abort(abort),
    .q(q_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] eq,
                       input logic eb, input logic ed);
    chk({tag, ".q"}, 32'(q_a), 32'(eq));
    chk({tag, ".busy"}, 32'(busy_a), 32'(eb));
    chk({tag, ".done"}, 32'(done_a), 32'(ed));
  endtask

  logic [7:0] exp_b;

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk_a("rst_a", 8'h00, 1'b0, 1'b0);
    chk("rst_b.q", 32'(q_b), 32'h0);
    step();
    chk_a("rst_hold", 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();

    // Logical left x3 at one step per clock.
    load = 1'b1; load_data = 8'b1011_0001;
    step();
    load = 1'b0;
    chk_a("ld1", 8'b1011_0001, 1'b0, 1'b0);
    start_a = 1'b1; step_count = 4'd3; dir = 1'b0; shift_type = 1'b0;
    step();
    start_a = 1'b0;
    chk_a("ll0", 8'b1011_0001, 1'b1, 1'b0);
    step();
    chk_a("ll1", 8'b0110_0010, 1'b1, 1'b0);
    step();
    chk_a("ll2", 8'b1100_0100, 1'b1, 1'b0);
    step();
    chk_a("ll3", 8'b1000_1000, 1'b0, 1'b1);
    step();
    chk_a("ll_hold", 8'b1000_1000, 1'b0, 1'b1);

    // Reload from DONE, then rotate right x2.
    load = 1'b1; load_data = 8'b1011_0001;
    step();
    load = 1'b0;
    chk_a("ld2", 8'b1011_0001, 1'b0, 1'b0);
    start_a = 1'b1; step_count = 4'd2; dir = 1'b1; shift_type = 1'b1;
    step();
    start_a = 1'b0;
    chk_a("rr0", 8'b1011_0001, 1'b1, 1'b0);
    step();
    chk_a("rr1", 8'b1101_1000, 1'b1, 1'b0);
    step();
    chk_a("rr2", 8'b0110_1100, 1'b0, 1'b1);

    // Zero-step run: straight to DONE, q untouched.
    start_a = 1'b1; step_count = 4'd0;
    step();
    start_a = 1'b0;
    chk_a("z0", 8'b0110_1100, 1'b0, 1'b1);

    // Paced run on dut b: two shifts, four clocks apiece.
    load = 1'b1; load_data = 8'b1011_0001;
    step();
    load = 1'b0;
    chk("ldb.q", 32'(q_b), 32'hB1);
    start_b = 1'b1; step_count = 4'd2; dir = 1'b0; shift_type = 1'b0;
    step();
    start_b = 1'b0;
    chk("tb0.busy", 32'(busy_b), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin load = 1'b1; load_data = 8'hFF; end
      if (i == 3) load = 1'b0;
      step();
      exp_b = (i < 4) ? 8'b1011_0001 :
              (i < 8) ? 8'b0110_0010 : 8'b1100_0100;
      chk($sformatf("tb%0d.q", i), 32'(q_b), 32'(exp_b));
      chk($sformatf("tb%0d.busy", i), 32'(busy_b), 32'(i < 8));
      chk($sformatf("tb%0d.done", i), 32'(done_b), 32'(i == 8));
    end

    // Abort on an edge where a shift is due.
    load = 1'b1; load_data = 8'h0F;
    step();
    load = 1'b0;
    start_a = 1'b1; step_count = 4'd3; dir = 1'b0; shift_type = 1'b0;
    step();
    start_a = 1'b0;
    step();
    chk_a("ab1", 8'h1E, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    chk_a("ab2", 8'h1E, 1'b0, 1'b0);
    step();
    abort = 1'b0;
    chk_a("ab_idle", 8'h1E, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a rotate-right run.
    load = 1'b1; load_data = 8'h81;
    step();
    load = 1'b0;
    start_a = 1'b1; step_count = 4'd5; dir = 1'b1; shift_type = 1'b1;
    step();
    start_a = 1'b0;
    step();
    chk_a("mr1", 8'hC0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_a("mr_rst", 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    step();
    chk_a("mr_after", 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xup_shift_seq_nbit.md
Name: xup_shift_seq_nbit

Overview:
- Sequential shift engine built around the combinational n-bit shift stage.
- Holds a SIZE-bit register and feeds it to the shift stage. On each paced step it writes the stage's output back into the register.
- After a programmed number of steps it reports done.
- Used by lab designs (e.g. LED chasers, serial framing) that need a shifted value to move over time.

Parameters:
- SIZE, 8: data width in bits.
- NBITS, 1: bit positions shifted per step. Legal range 1 to SIZE-1.
- CNT_W, 4: width of the step-count input. Maximum run is 2^CNT_W-1 steps.
- TICK_DIV, 1: clock cycles per step. Must be at least 1; 1 means one step every clock.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  capture load_data into the register (synchronous).
- load_data  in  SIZE  parallel value to capture.
- start  in  1  begin a run of step_count steps.
- step_count  in  CNT_W  number of shift steps in the run.
- dir  in  1  0 = shift left, 1 = shift right; latched at start.
- shift_type  in  1  0 = logical (zero fill), 1 = rotate; latched at start.
- abort  in  1  terminate a run early.
- q  out  SIZE  current register value.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.

Behaviour:
- Reset (reset_n=0, applied asynchronously):
  - q=0, busy=0, done=0.
  - state=IDLE; remaining-step counter=0; tick counter=0.
  - Latched dir=0 and shift_type=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE/DONE, load=1: q<=load_data; next state IDLE. load has priority; start is ignored that cycle.
- IDLE/DONE, start=1, load=0:
  - Latch dir, shift_type and step_count.
  - Clear the tick counter.
  - If step_count=0: next state DONE, q unchanged.
  - Otherwise: next state RUN.
- RUN:
  - The tick counter increments every cycle.
  - When the tick counter reaches TICK_DIV-1, on that edge:
    - q <= shift(q), using the latched dir and shift_type, by NBITS.
    - Clear the tick counter; decrement remaining.
    - If remaining was 1, next state DONE.
- Latency: with start sampled at edge k, the step count N and TICK_DIV=T:
  - The first shift lands at edge k+T.
  - The final shift lands at edge k+N*T.
  - busy=1 for exactly N*T cycles; done rises on the same edge as the final shift.
- In RUN, load and start are ignored.
- abort=1 in RUN: next state IDLE; q holds its last value; counters clear. Abort takes priority over a shift due on the same edge (no shift occurs).
- abort=1 in IDLE/DONE is ignored.
- DONE holds until the next load or start. A start from DONE re-runs on the current q (chaining is allowed).
- Shift function:
  - Logical left: q<<NBITS, zero fill at the LSBs.
  - Logical right: q>>NBITS, zero fill at the MSBs.
  - Rotate: the bits shifted out re-enter at the opposite end.
- Reset asserted mid-run: immediate return to reset values. Nothing resumes after reset_n is released.
- Outputs q, busy and done are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - DIR_LEFT=0, DIR_RIGHT=1;
  - SHIFT_LOGICAL=0, SHIFT_ROTATE=1.
- One sub-module: the existing xup_shift_nbit (SIZE and NBITS passed through, DELAY=0). It is instantiated as the combinational next-value stage: parallel_in=q, dir and shift_type driven from the latched copies.
- This block contains only the FSM, the counters and the register.

Test Plan:
- SIZE=8, NBITS=1, T=1. Load 8'b1011_0001; start with step_count=3, dir=0, shift_type=0:
  - q steps 0110_0010, 1100_0100, 1000_1000;
  - busy high for 3 cycles; done=1 after the third edge.
- From DONE, load 8'b1011_0001, then start with step_count=2, dir=1, shift_type=1:
  - q steps 1101_1000, then 0110_1100;
  - done=1 after 2 cycles.
- start with step_count=0:
  - done=1 on the next edge; busy never asserts; q unchanged.
- TICK_DIV=4, step_count=2:
  - q changes only at edges k+4 and k+8; busy high for 8 cycles.
  - load asserted mid-run with 8'hFF is ignored.
- Mid-run abort and mid-run reset:
  - abort on the cycle a shift is due: q unchanged, state IDLE, busy=0, done=0 next cycle.
  - reset_n pulsed low mid-run: q=0, busy=0 and done=0 immediately, without a clock edge.
